// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI-style five-channel slave in front of a 2^ADDR_W x DATA_W register array
//   clk, rst            : clock, synchronous active-high reset
//   read_address/AR_*   : read address channel
//   data_read/R_*       : read data channel (registered)
//   write_address/AW_*  : write address channel
//   data_write/W_*      : write data channel
//   B_*                 : write response channel
module axi_mem_slave #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_address,
    input  logic              AR_VALID,
    output logic              AR_READY,
    output logic [DATA_W-1:0] data_read,
    output logic              R_VALID,
    input  logic              R_READY,
    input  logic [ADDR_W-1:0] write_address,
    input  logic              AW_VALID,
    output logic              AW_READY,
    input  logic [DATA_W-1:0] data_write,
    input  logic              W_VALID,
    output logic              W_READY,
    output logic              B_VALID,
    input  logic              B_READY
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    r_state_e          r_state_q, r_state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] data_read_q, data_read_d;
    logic              aw_held_q, aw_held_d, w_held_q, w_held_d, b_valid_q, b_valid_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic              ar_hs, aw_hs, w_hs, commit;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    assign AR_READY  = !rst && r_state_q == R_IDLE;
    assign AW_READY  = !rst && !aw_held_q && !b_valid_q;
    assign W_READY   = !rst && !w_held_q && !b_valid_q;
    assign R_VALID   = r_state_q == R_DATA;
    assign data_read = data_read_q;
    assign B_VALID   = b_valid_q;

    assign ar_hs   = AR_VALID && AR_READY;
    assign aw_hs   = AW_VALID && AW_READY;
    assign w_hs    = W_VALID && W_READY;
    // Commit as soon as both halves are present, whether held or arriving now.
    assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign wr_addr = aw_held_q ? aw_addr_q : write_address;
    assign wr_data = w_held_q ? w_data_q : data_write;

    always_comb begin
        r_state_d   = r_state_q;
        data_read_d = data_read_q;
        if (r_state_q == R_IDLE) begin
            if (ar_hs) begin
                r_state_d   = R_DATA;
                data_read_d = mem_q[read_address];
            end
        end else if (R_READY) begin
            r_state_d = R_IDLE;
        end
        aw_held_d = commit ? 1'b0 : (aw_held_q || aw_hs);
        w_held_d  = commit ? 1'b0 : (w_held_q || w_hs);
        aw_addr_d = aw_hs ? write_address : aw_addr_q;
        w_data_d  = w_hs ? data_write : w_data_q;
        b_valid_d = commit || (b_valid_q && !B_READY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= R_IDLE;
            data_read_q <= '0;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            b_valid_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            r_state_q   <= r_state_d;
            data_read_q <= data_read_d;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            aw_addr_q   <= aw_addr_d;
            w_data_q    <= w_data_d;
            b_valid_q   <= b_valid_d;
            // Non-blocking write: a same-edge read above sees the old word.
            if (commit) mem_q[wr_addr] <= wr_data;
        end
    end
endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: randomized and directed scoreboard bench for axi_mem_slave
module tb_axi_mem_slave;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] read_address, write_address;
    logic       AR_VALID, AR_READY, R_VALID, R_READY;
    logic       AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
    logic [7:0] data_read, data_write;

    int checks = 0;
    int errors = 0;

    axi_mem_slave #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .read_address(read_address), .AR_VALID(AR_VALID), .AR_READY(AR_READY),
        .data_read(data_read), .R_VALID(R_VALID), .R_READY(R_READY),
        .write_address(write_address), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
        .data_write(data_write), .W_VALID(W_VALID), .W_READY(W_READY),
        .B_VALID(B_VALID), .B_READY(B_READY)
    );

    always #5 clk = ~clk;

    // Reference model: a plain array plus queues of outstanding responses.
    logic [7:0] ref_mem [16];
    logic [7:0] rq [$];
    int         b_pend;
    logic       aw_h, w_h;
    logic [3:0] ha;
    logic [7:0] hd, last_dr;

    always @(posedge clk) begin
        if (rst) begin
            foreach (ref_mem[i]) ref_mem[i] = 8'h00;
            rq.delete();
            b_pend  = 0;
            aw_h    = 1'b0;
            w_h     = 1'b0;
            last_dr = 8'h00;
        end else begin
            automatic bit ar_ok = rq.size() == 0;
            automatic bit aw_ok = !aw_h && b_pend == 0;
            automatic bit w_ok  = !w_h && b_pend == 0;
            if (rq.size() != 0 && R_READY) last_dr = rq.pop_front();
            if (ar_ok && AR_VALID) rq.push_back(ref_mem[read_address]);
            if (b_pend != 0 && B_READY) b_pend--;
            if (aw_ok && AW_VALID) begin aw_h = 1'b1; ha = write_address; end
            if (w_ok && W_VALID) begin w_h = 1'b1; hd = data_write; end
            if (aw_h && w_h) begin
                ref_mem[ha] = hd;
                aw_h = 1'b0;
                w_h = 1'b0;
                b_pend++;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every DUT output against the model half a cycle after each edge.
    always @(negedge clk) begin
        chk("R_VALID", {7'b0, R_VALID}, {7'b0, rq.size() != 0});
        chk("data_read", data_read, rq.size() != 0 ? rq[0] : last_dr);
        chk("B_VALID", {7'b0, B_VALID}, {7'b0, b_pend != 0});
        chk("AR_READY", {7'b0, AR_READY}, {7'b0, !rst && rq.size() == 0});
        chk("AW_READY", {7'b0, AW_READY}, {7'b0, !rst && !aw_h && b_pend == 0});
        chk("W_READY", {7'b0, W_READY}, {7'b0, !rst && !w_h && b_pend == 0});
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [3:0] a);
        read_address = a;
        AR_VALID = 1'b1;
        cyc(1);
        AR_VALID = 1'b0;
        cyc(2);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        write_address = a;
        data_write = d;
        AW_VALID = 1'b1;
        W_VALID = 1'b1;
        cyc(1);
        AW_VALID = 1'b0;
        W_VALID = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {AR_VALID, AW_VALID, W_VALID} = '0;
        read_address = '0;
        write_address = '0;
        data_write = '0;
        R_READY = 1'b1;
        B_READY = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        rd(4'h5);
        wr(4'h5, 8'hAA);
        cyc(2);
        rd(4'h5);
        data_write = 8'h3C;
        W_VALID = 1'b1;
        cyc(1);
        W_VALID = 1'b0;
        cyc(2);
        write_address = 4'h9;
        AW_VALID = 1'b1;
        cyc(1);
        AW_VALID = 1'b0;
        cyc(2);
        rd(4'h9);
        R_READY = 1'b0;
        read_address = 4'h5;
        AR_VALID = 1'b1;
        cyc(1);
        AR_VALID = 1'b0;
        cyc(4);
        R_READY = 1'b1;
        cyc(2);
        B_READY = 1'b0;
        wr(4'h3, 8'h11);
        write_address = 4'h4;
        data_write = 8'h22;
        AW_VALID = 1'b1;
        W_VALID = 1'b1;
        cyc(3);
        B_READY = 1'b1;
        cyc(3);
        AW_VALID = 1'b0;
        W_VALID = 1'b0;
        cyc(2);
        rd(4'h4);
        rd(4'h3);
        read_address = 4'h2;
        AR_VALID = 1'b1;
        wr(4'h2, 8'h77);
        AR_VALID = 1'b0;
        cyc(2);
        rd(4'h2);
        B_READY = 1'b0;
        wr(4'h2, 8'h55);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        B_READY = 1'b1;
        cyc(1);
        rd(4'h2);
        for (int i = 0; i < 600; i++) begin
            AR_VALID = 1'($urandom_range(0, 1));
            AW_VALID = 1'($urandom_range(0, 1));
            W_VALID = 1'($urandom_range(0, 1));
            R_READY = 1'($urandom_range(0, 1));
            B_READY = 1'($urandom_range(0, 1));
            read_address = 4'($urandom_range(0, 15));
            write_address = 4'($urandom_range(0, 15));
            data_write = 8'($urandom);
            rst = $urandom_range(0, 99) == 0;
            cyc(1);
        end
        {AR_VALID, AW_VALID, W_VALID, rst} = '0;
        R_READY = 1'b1;
        B_READY = 1'b1;
        cyc(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_mem_slave.md
# axi_mem_slave

AXI-style memory-mapped slave implementing all five channels (AR, R, AW, W, B) in front of a 2^ADDR_W x DATA_W register array. It sits directly downstream of `AXI_Master`, connects port-for-port to its interconnect signals, and services both its read and write transactions. Read and write paths are independent and may run concurrently.

## Interface
- `ADDR_W`, 4, address width; array depth = 2^ADDR_W
- `DATA_W`, 8, data width

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous reset, active-high
- `read_address`  in  ADDR_W  read address (AR)
- `AR_VALID`  in  1  master read address valid
- `AR_READY`  out  1  slave can accept read address
- `data_read`  out  DATA_W  read data (R)
- `R_VALID`  out  1  read data valid
- `R_READY`  in  1  master accepts read data
- `write_address`  in  ADDR_W  write address (AW)
- `AW_VALID`  in  1  write address valid
- `AW_READY`  out  1  slave can accept write address
- `data_write`  in  DATA_W  write data (W)
- `W_VALID`  in  1  write data valid
- `W_READY`  out  1  slave can accept write data
- `B_VALID`  out  1  write response valid
- `B_READY`  in  1  master accepts write response

## Operation
- Reset: every array word = 0; `data_read`=0, `R_VALID`=0, `B_VALID`=0; `AR_READY`, `AW_READY`, `W_READY` forced 0 while `rst`=1; internal state cleared.
- Handshake on any channel = VALID & READY sampled high at a rising edge.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: `AR_READY`=1. AR handshake -> register `data_read` = mem[`read_address`], `R_VALID`=1, go R_DATA.
  - R_DATA: `AR_READY`=0; `data_read`, `R_VALID` held stable until `R_READY`=1 at an edge -> `R_VALID`=0, back to R_IDLE.
- Write path: flags `aw_held`, `w_held`, registers `aw_addr`, `w_data`, plus B state.
  - `AW_READY` = !`aw_held` & !`B_VALID`; `W_READY` = !`w_held` & !`B_VALID`.
  - AW handshake captures `write_address`; W handshake captures `data_write`. AW and W may arrive in either order or the same cycle.
  - Commit edge: the edge where address and data are both available (held or handshaking this edge). At it: mem[addr] <= data, both flags cleared, `B_VALID`<=1.
  - `B_VALID` holds until `B_READY`=1 at an edge, then clears. No new AW/W accepted while `B_VALID`=1.
- Read/write same address, same edge (AR handshake with write commit): read returns the pre-write value.
- Full address decode; no out-of-range case.

## Timing
- Read latency: AR handshake at edge N -> `R_VALID`=1 and valid data after edge N. Throughput: at most 1 read per 2 cycles when `R_READY` is tied high.
- Write latency: commit at edge N -> `B_VALID`=1 after edge N; memory visible to an AR handshake at edge N+1 or later.
- Write throughput: at most 1 write per 2 cycles (commit cycle, then B accept cycle).
- READY outputs are combinational decodes of registered state only, never of VALID inputs.
- Dropping VALID before handshake: no capture, no side effect.
- Reset mid-transaction: held address/data and pending R/B are discarded. The array is cleared. Outputs read their reset values on the cycle after the reset edge.

## Test plan
- Reset, then AR handshake at address 0x5 with `R_READY`=1 -> `R_VALID`=1 for exactly one cycle, `data_read`=0x00.
- AW 0x5 and W 0xAA in the same cycle, `B_READY`=1 -> `B_VALID` pulses one cycle; a subsequent read of 0x5 returns 0xAA.
- W 0x3C two cycles before AW 0x9 -> `W_READY`=0 while waiting, commit on the AW edge; a read of 0x9 returns 0x3C.
- `R_READY`=0 for 4 cycles after a read of 0x5 (0xAA) -> `R_VALID` and `data_read`=0xAA stay stable and `AR_READY`=0; the read completes when `R_READY` rises.
- `B_READY`=0 for 3 cycles -> `B_VALID` held, `AW_READY`=`W_READY`=0; a second write is accepted only after the B handshake.
- Write 0x77 to 0x2 commits on the same edge as an AR to 0x2 -> `data_read` is the old value (0x00); a subsequent read returns 0x77. Assert `rst` while `B_VALID`=1 -> all outputs reset, and a read of 0x2 returns 0x00.
